// File: rtl/enha_pkg.sv
// Shared definitions for the block enhancement-rate generator.
//   TH_HI/TH_MID/TH_LO : block-peak thresholds for the rate quantiser
//   enha_rate_t        : 2-bit rate; bit1 selects the half term, bit0 the quarter term
package enha_pkg;

    localparam logic [7:0] TH_HI  = 8'd192;
    localparam logic [7:0] TH_MID = 8'd128;
    localparam logic [7:0] TH_LO  = 8'd64;

    typedef enum logic [1:0] {
        RATE_NONE = 2'b00,  // no attenuation
        RATE_Q    = 2'b01,  // subtract 1/4
        RATE_H    = 2'b10,  // subtract 1/2
        RATE_HQ   = 2'b11   // subtract 3/4
    } enha_rate_t;

endpackage

// File: rtl/enha_rate_quant.sv
// Combinational quantiser: 8-bit block peak -> 2-bit enhancement rate.
//   i_peak    : block peak luminance (unsigned)
//   o_rate_c  : rate consumed by the per-pixel enhancement selector
module enha_rate_quant
    import enha_pkg::*;
(
    input  logic [7:0] i_peak,
    output enha_rate_t o_rate_c
);

    // Brighter blocks get less attenuation.
    always_comb begin
        o_rate_c = RATE_HQ;
        if (i_peak >= TH_HI) begin
            o_rate_c = RATE_NONE;
        end else if (i_peak >= TH_MID) begin
            o_rate_c = RATE_Q;
        end else if (i_peak >= TH_LO) begin
            o_rate_c = RATE_H;
        end
    end

endmodule

// File: rtl/block_enha_rate_gen.sv
// Per-block peak tracker and double-buffered enhancement-rate table.
// Accumulates the peak luminance of each BLK_W x BLK_H block over a frame,
// quantises every peak at frame end and commits the rates to a bank that the
// next frame's pixel path reads through a registered random-access port.
//   iODCK      : pixel clock (rising edge)
//   iRST       : synchronous active-low reset
//   iVS        : one-cycle frame-start pulse
//   iDE        : pixel valid
//   iBpixel    : pixel luminance
//   iRdBlk     : raster block index to read (by*NBX+bx)
//   oEnhaRate  : rate of iRdBlk from the last completed frame, 1-cycle latency
//   oFrameDone : one-cycle pulse after a new bank is committed
//   oBusy      : frame accumulation in progress
module block_enha_rate_gen
    import enha_pkg::*;
#(
    parameter int unsigned IMG_W = 1024,
    parameter int unsigned IMG_H = 768,
    parameter int unsigned BLK_W = 128,
    parameter int unsigned BLK_H = 128,
    parameter int unsigned IDXW  = $clog2((IMG_W / BLK_W) * (IMG_H / BLK_H))
) (
    input  logic            iODCK,
    input  logic            iRST,
    input  logic            iVS,
    input  logic            iDE,
    input  logic [7:0]      iBpixel,
    input  logic [IDXW-1:0] iRdBlk,
    output logic [1:0]      oEnhaRate,
    output logic            oFrameDone,
    output logic            oBusy
);

    localparam int unsigned NBX = IMG_W / BLK_W;
    localparam int unsigned NBY = IMG_H / BLK_H;
    localparam int unsigned NB  = NBX * NBY;
    localparam int unsigned BIW = (NB    > 1) ? $clog2(NB)    : 1;
    localparam int unsigned CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned BCW = (BLK_W > 1) ? $clog2(BLK_W) : 1;
    localparam int unsigned BRW = (BLK_H > 1) ? $clog2(BLK_H) : 1;
    localparam int unsigned BXW = (NBX   > 1) ? $clog2(NBX)   : 1;
    localparam int unsigned BYW = (NBY   > 1) ? $clog2(NBY)   : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ACC    = 2'b01,
        S_COMMIT = 2'b10
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;
    logic            r_busy;
    logic            r_done;

    logic [CW-1:0]   r_col;
    logic [RW-1:0]   r_row;
    logic [BCW-1:0]  r_bcol;
    logic [BRW-1:0]  r_brow;
    logic [BXW-1:0]  r_bx;
    logic [BYW-1:0]  r_by;

    logic [7:0]      r_max  [NB];
    enha_rate_t      r_bank [NB];
    enha_rate_t      w_quant[NB];
    enha_rate_t      w_rate_rd;
    enha_rate_t      r_rate;

    logic            w_acc;
    logic            w_last;
    logic            w_commit;
    logic            w_col_wrap;
    logic [BIW-1:0]  w_blk;
    logic [BIW-1:0]  w_rd_idx;
    logic            w_rd_oob;

    assign w_acc      = iDE & ~iVS & (r_state == S_ACC);
    assign w_col_wrap = (r_col == CW'(IMG_W - 1));
    assign w_last     = w_col_wrap & (r_row == RW'(IMG_H - 1));
    assign w_commit   = (r_state == S_COMMIT);
    assign w_blk      = BIW'(32'(r_by) * NBX + 32'(r_bx));
    assign w_rd_idx   = BIW'(iRdBlk);
    assign w_rd_oob   = (32'(iRdBlk) >= NB);

    // FSM state register.
    always_ff @(posedge iODCK) begin
        if (!iRST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next state: iVS always (re)starts a frame and discards any partial one.
    always_comb begin
        w_state_nxt = r_state;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        if (iVS) begin
            w_state_nxt = S_ACC;
        end else begin
            case (r_state)
                S_ACC:    if (w_acc && w_last) w_state_nxt = S_COMMIT;
                S_COMMIT: w_state_nxt = S_IDLE;
                default:  w_state_nxt = r_state;
            endcase
        end
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_done_nxt = w_commit;
    end

    // Raster and block position counters; block coordinates counted, never divided.
    always_ff @(posedge iODCK) begin
        if (!iRST || iVS) begin
            r_col  <= '0;
            r_row  <= '0;
            r_bcol <= '0;
            r_brow <= '0;
            r_bx   <= '0;
            r_by   <= '0;
        end else if (w_acc) begin
            if (w_col_wrap) begin
                r_col  <= '0;
                r_bcol <= '0;
                r_bx   <= '0;
                if (w_last) begin
                    r_row  <= '0;
                    r_brow <= '0;
                    r_by   <= '0;
                end else begin
                    r_row <= r_row + RW'(1);
                    if (r_brow == BRW'(BLK_H - 1)) begin
                        r_brow <= '0;
                        r_by   <= r_by + BYW'(1);
                    end else begin
                        r_brow <= r_brow + BRW'(1);
                    end
                end
            end else begin
                r_col <= r_col + CW'(1);
                if (r_bcol == BCW'(BLK_W - 1)) begin
                    r_bcol <= '0;
                    r_bx   <= r_bx + BXW'(1);
                end else begin
                    r_bcol <= r_bcol + BCW'(1);
                end
            end
        end
    end

    // Running per-block maxima.
    always_ff @(posedge iODCK) begin
        if (!iRST || iVS) begin
            for (int i = 0; i < int'(NB); i++) begin
                r_max[i] <= 8'd0;
            end
        end else if (w_acc && (iBpixel > r_max[w_blk])) begin
            r_max[w_blk] <= iBpixel;
        end
    end

    // One quantiser per block so the whole bank commits in a single edge.
    for (genvar g = 0; g < int'(NB); g++) begin : g_quant
        enha_rate_quant u_quant (
            .i_peak   (r_max[g]),
            .o_rate_c (w_quant[g])
        );
    end

    // Committed rate bank.
    always_ff @(posedge iODCK) begin
        if (!iRST) begin
            for (int i = 0; i < int'(NB); i++) begin
                r_bank[i] <= RATE_NONE;
            end
        end else if (w_commit) begin
            for (int i = 0; i < int'(NB); i++) begin
                r_bank[i] <= w_quant[i];
            end
        end
    end

    // Read port is write-first: on the commit edge it returns the new rate.
    always_comb begin
        w_rate_rd = RATE_NONE;
        if (!w_rd_oob) begin
            w_rate_rd = w_commit ? w_quant[w_rd_idx] : r_bank[w_rd_idx];
        end
    end

    always_ff @(posedge iODCK) begin
        if (!iRST) begin
            r_rate <= RATE_NONE;
        end else begin
            r_rate <= w_rate_rd;
        end
    end

    assign oEnhaRate  = r_rate;
    assign oFrameDone = r_done;
    assign oBusy      = r_busy;

endmodule

// File: tb/tb_block_enha_rate_gen.sv
// Directed bench for block_enha_rate_gen on an 8x4 image of 4x2 blocks (NB=4).
// iRdBlk is widened to 3 bits so an out-of-range index can be presented.
module tb_block_enha_rate_gen;

    logic       clk;
    logic       rst_n;
    logic       vs;
    logic       de;
    logic [7:0] pix;
    logic [2:0] rd_blk;
    logic [1:0] rate;
    logic       done;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int base;

    logic [7:0] fbuf [32];
    logic [7:0] peak [4];

    block_enha_rate_gen #(
        .IMG_W (8),
        .IMG_H (4),
        .BLK_W (4),
        .BLK_H (2),
        .IDXW  (3)
    ) dut (
        .iODCK      (clk),
        .iRST       (rst_n),
        .iVS        (vs),
        .iDE        (de),
        .iBpixel    (pix),
        .iRdBlk     (rd_blk),
        .oEnhaRate  (rate),
        .oFrameDone (done),
        .oBusy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt = done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_vs();
        vs = 1'b1;
        tick();
        vs = 1'b0;
    endtask

    task automatic send_pix(input logic [7:0] v);
        de  = 1'b1;
        pix = v;
        tick();
        de  = 1'b0;
    endtask

    // Streams fbuf[0..30]; the caller sends the last pixel so it can check timing.
    task automatic stream_head(input bit gaps);
        for (int i = 0; i < 31; i++) begin
            send_pix(fbuf[i]);
            if (gaps) tick();
        end
    endtask

    // Fills fbuf so block b peaks at peak[b] (pixel index i%3==0 carries the peak).
    task automatic fill_peaks();
        for (int i = 0; i < 32; i++) begin
            int r, c, b;
            r = i / 8;
            c = i % 8;
            b = (r / 2) * 2 + (c / 4);
            fbuf[i] = peak[b] - 8'(i % 3);
        end
    endtask

    task automatic read_all(input string tag, input logic [1:0] e0, input logic [1:0] e1,
                            input logic [1:0] e2, input logic [1:0] e3);
        logic [1:0] exp [4];
        exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
        for (int b = 0; b < 4; b++) begin
            rd_blk = 3'(b);
            tick();
            chk($sformatf("%s_blk%0d", tag, b), 32'(rate), 32'(exp[b]));
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        vs     = 1'b0;
        de     = 1'b0;
        pix    = 8'd0;
        rd_blk = 3'd0;

        // Reset state
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rate", 32'(rate), 32'd0);
        rst_n = 1'b1;
        // DE before any iVS must be ignored
        send_pix(8'd255);
        read_all("rst", 2'b00, 2'b00, 2'b00, 2'b00);
        chk("rst_done_cnt", 32'(done_cnt), 32'd0);

        // Frame 1: peaks 200/150/100/10
        peak[0] = 8'd200; peak[1] = 8'd150; peak[2] = 8'd100; peak[3] = 8'd10;
        fill_peaks();
        pulse_vs();
        chk("f1_busy_after_vs", 32'(busy), 32'd1);
        stream_head(1'b0);
        send_pix(fbuf[31]);
        chk("f1_done_at_last", 32'(done), 32'd0);
        chk("f1_busy_at_last", 32'(busy), 32'd1);
        tick();
        chk("f1_done_pulse", 32'(done), 32'd1);
        chk("f1_busy_clear", 32'(busy), 32'd0);
        tick();
        chk("f1_done_low", 32'(done), 32'd0);
        read_all("f1", 2'b00, 2'b01, 2'b10, 2'b11);

        // Threshold edges: single peaks 192/191/64/63, last pixel carries block 3
        for (int i = 0; i < 32; i++) fbuf[i] = 8'd0;
        fbuf[9]  = 8'd192;
        fbuf[13] = 8'd191;
        fbuf[24] = 8'd64;
        fbuf[31] = 8'd63;
        pulse_vs();
        stream_head(1'b0);
        send_pix(fbuf[31]);
        tick();
        chk("th_done_pulse", 32'(done), 32'd1);
        read_all("th", 2'b00, 2'b01, 2'b10, 2'b11);

        // Abort: partial frame of 255s discarded by a second iVS
        base = done_cnt;
        pulse_vs();
        for (int i = 0; i < 20; i++) send_pix(8'd255);
        pulse_vs();
        for (int i = 0; i < 32; i++) fbuf[i] = 8'd0;
        stream_head(1'b0);
        send_pix(fbuf[31]);
        tick();
        tick();
        tick();
        chk("abort_one_pulse", 32'(done_cnt - base), 32'd1);
        read_all("abort", 2'b11, 2'b11, 2'b11, 2'b11);

        // Gapped frame of 128 with iRdBlk=2 held through the commit
        base = done_cnt;
        for (int i = 0; i < 32; i++) fbuf[i] = 8'd128;
        rd_blk = 3'd2;
        pulse_vs();
        stream_head(1'b1);
        send_pix(fbuf[31]);
        chk("hold_old_rate", 32'(rate), 32'd3);
        chk("gap_done_at_last", 32'(done), 32'd0);
        tick();
        chk("hold_new_rate", 32'(rate), 32'd1);
        chk("gap_done_pulse", 32'(done), 32'd1);
        for (int i = 0; i < 5; i++) send_pix(8'd255);
        tick();
        tick();
        chk("stray_one_pulse", 32'(done_cnt - base), 32'd1);
        chk("stray_busy", 32'(busy), 32'd0);
        read_all("gap", 2'b01, 2'b01, 2'b01, 2'b01);
        rd_blk = 3'd5;
        tick();
        chk("oob_rd5", 32'(rate), 32'd0);
        rd_blk = 3'd7;
        tick();
        chk("oob_rd7", 32'(rate), 32'd0);

        // Reset mid-frame, then a fresh frame with peaks 100/10/200/150
        pulse_vs();
        for (int i = 0; i < 10; i++) send_pix(8'd255);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        rd_blk = 3'd1;
        tick();
        chk("mid_rst_bank", 32'(rate), 32'd0);
        peak[0] = 8'd100; peak[1] = 8'd10; peak[2] = 8'd200; peak[3] = 8'd150;
        fill_peaks();
        pulse_vs();
        stream_head(1'b0);
        send_pix(fbuf[31]);
        tick();
        chk("post_rst_done", 32'(done), 32'd1);
        read_all("post_rst", 2'b10, 2'b11, 2'b00, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/block_enha_rate_gen.md
Name: block_enha_rate_gen

Overview:
- Upstream neighbour of the per-pixel enhancement selector.
- Scans each frame's pixel stream and tracks the peak 8-bit luminance of every rectangular block.
- At frame end, quantises each block peak to the 2-bit enhancement rate that the selector consumes.
- Results are double-buffered: the pixel path of frame N+1 reads the rates computed from frame N through a random-access read port.

Parameters:
- IMG_W, 1024, active pixels per line
- IMG_H, 768, active lines per frame
- BLK_W, 128, block width in pixels; IMG_W must be a multiple of BLK_W
- BLK_H, 128, block height in lines; IMG_H must be a multiple of BLK_H
- NBX/NBY, derived, IMG_W/BLK_W and IMG_H/BLK_H; NB = NBX*NBY
- IDXW, derived, $clog2(NB)

Ports:
- iODCK  in  1  pixel clock; all logic is on the rising edge
- iRST  in  1  reset, synchronous, active-low
- iVS  in  1  frame-start pulse, one cycle, precedes the first active pixel
- iDE  in  1  pixel valid
- iBpixel  in  8  pixel luminance, sampled when iDE=1
- iRdBlk  in  IDXW  block index to read, raster order, = by*NBX+bx
- oEnhaRate  out  2  rate for iRdBlk from the last completed frame
- oFrameDone  out  1  one-cycle pulse; a new result bank was committed
- oBusy  out  1  a frame is being accumulated (after iVS, before completion)

Behaviour:
- Reset (iRST=0 at an edge): counters=0; all running maxima=0; committed bank=all rate 0; oEnhaRate=0; oFrameDone=0; oBusy=0. Reset is honoured mid-frame and discards the partial frame.
- iVS=1: clears the column, row and block counters and the running-max array, then sets oBusy=1.
  - If iVS arrives mid-frame, the partial frame is discarded: no commit, no oFrameDone.
  - iVS has priority over iDE in the same cycle; that pixel is dropped.
- Accumulation: on iDE=1 with oBusy=1:
  - col increments and wraps at IMG_W-1; row increments when col wraps.
  - bx=col/BLK_W and by=row/BLK_H are kept as separate incrementing counters; no dividers.
  - max[by*NBX+bx] <= max(current value, iBpixel).
  - iDE while oBusy=0 is ignored, including extra pixels after completion or before the first iVS.
- Completion: the edge that accepts pixel (IMG_W-1, IMG_H-1) schedules commit.
  - On the next edge, every committed rate is written from quant(max including that last pixel), oFrameDone=1 for one cycle, and oBusy=0.
  - Latency from the last pixel to oFrameDone is 1 cycle.
- Quantiser (block peak -> rate):
  - peak >= 192 -> 2'b00 (no attenuation)
  - 128..191 -> 2'b01 (subtract 1/4)
  - 64..127 -> 2'b10 (subtract 1/2)
  - 0..63 -> 2'b11 (subtract 3/4)
  - These encodings match the selector's bit meaning: bit1 selects the half term, bit0 selects the quarter term.
- Read port: oEnhaRate is registered, so it is valid 1 cycle after iRdBlk is presented.
  - On the commit edge, a read presented that cycle returns the new value (write-first).
  - iRdBlk >= NB returns 2'b00.
- All compares are unsigned 8-bit; the running max never overflows.

Decomposition:
- Package enha_pkg holds:
  - localparams TH_HI=8'd192, TH_MID=8'd128, TH_LO=8'd64;
  - typedef enha_rate_t (2-bit) with named values RATE_NONE, RATE_Q, RATE_H, RATE_HQ.
- One sub-module, enha_rate_quant: purely combinational, 8-bit peak -> enha_rate_t. It is instantiated once per block, or once with a loop over the array at commit.
- Storage for the running-max array and the committed array is flip-flops; NB is small.

Test Plan (IMG_W=8, IMG_H=4, BLK_W=4, BLK_H=2, giving NB=4):
- Reset, then read blocks 0..3 -> oEnhaRate=0 for all; oFrameDone=0; oBusy=0.
- iVS, then a frame with block 0 max=200, block 1=150, block 2=100, block 3=10 -> oFrameDone 1 cycle after the 32nd pixel; reads give 00, 01, 10, 11.
- Threshold edges: single-peak blocks at 192, 191, 64, 63 -> 00, 01, 10, 11.
- Abort: iVS, 20 pixels all 255, iVS again, full frame of 0s -> exactly one oFrameDone; all rates 11.
- iDE gaps plus extra pixels after completion: gapped frame of value 128, then 5 stray DE pixels of 255 -> all rates 01; no second pulse.
- iRdBlk=2 held through commit -> old value before the commit edge, new value on the cycle after the commit edge; iRdBlk=5 -> 00.
- Assert iRST=0 mid-frame, release, run a full frame -> rates reflect only the post-reset frame.
